// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
//
// Multi-digit BCD adder that processes one digit pair per clock, least
// significant digit first, through a single one-digit add/correct slice.
// Operands are captured on an accepted start; the result is held stable
// after done until the next accepted start. Operand digits above 9 raise
// error (board LEDR convention); the arithmetic still runs on them.
//
// Optional feature (macro BCD_SAT_EN):
//   defined   - on a final decimal carry, sum saturates to all 9s, cout=1.
//   undefined - sum wraps modulo 10^DIGITS, cout reports the overflow.
//
// Parameters:
//   DIGITS     number of BCD digits per operand (>=1)
//
// Ports:
//   clock      in   1          system clock, rising edge
//   reset      in   1          asynchronous, active-high reset
//   start      in   1          operation request, sampled only in IDLE
//   a, b       in   4*DIGITS   packed BCD operands, digit 0 in [3:0]
//   cin        in   1          carry into digit 0
//   busy       out  1          high while digits are being processed
//   done       out  1          one-cycle pulse when sum/cout are valid
//   sum        out  4*DIGITS   packed BCD result
//   cout       out  1          decimal carry out of the top digit
//   error      out  1          a captured operand digit was > 9
//   state_dbg  out  2          current FSM state (0=IDLE, 1=ADD, 2=FIN)
//
// Handshake: start is a level request, accepted on any rising edge where
// the FSM is in IDLE; it is ignored in ADD and FIN. done pulses for exactly
// one cycle and sum/cout/error then hold until the next accepted start.
// -----------------------------------------------------------------------------
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  error,
  output logic [1:0]            state_dbg
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [W-1:0]    a_q, a_n;
  logic [W-1:0]    b_q, b_n;
  logic            carry_q, carry_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [W-1:0]    sum_q, sum_n;
  logic            cout_q, cout_n;
  logic            error_q, error_n;

  // One-digit BCD slice. The operand registers are shifted right by a digit
  // each ADD cycle, so the current digit pair always sits in bits [3:0].
  logic [4:0]      slice_t;
  logic [3:0]      slice_digit;
  logic            slice_carry;

  function automatic logic any_invalid(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    slice_t     = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(carry_q);
    slice_digit = slice_t[3:0];
    slice_carry = 1'b0;
    if (slice_t > 5'd9) begin
      // Adding 6 skips the six unused codes; only the low nibble is kept.
      slice_digit = slice_t[3:0] + 4'd6;
      slice_carry = 1'b1;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    carry_n = carry_q;
    idx_n   = idx_q;
    sum_n   = sum_q;
    cout_n  = cout_q;
    error_n = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = ADD;
          a_n     = a;
          b_n     = b;
          carry_n = cin;
          idx_n   = '0;
          sum_n   = '0;
          error_n = any_invalid(a) | any_invalid(b);
        end
      end

      ADD: begin
        for (int d = 0; d < DIGITS; d++) begin
          if (idx_q == IW'(d)) sum_n[4*d +: 4] = slice_digit;
        end
        a_n     = a_q >> 4;
        b_n     = b_q >> 4;
        carry_n = slice_carry;
        idx_n   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_n = FIN;
          idx_n   = '0;
          cout_n  = slice_carry;
`ifdef BCD_SAT_EN
          if (slice_carry) sum_n = {DIGITS{4'h9}};
`endif
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      carry_q <= carry_n;
      idx_q   <= idx_n;
      sum_q   <= sum_n;
      cout_q  <= cout_n;
      error_q <= error_n;
    end
  end

  // busy/done decode straight from the state register, so reset drops them
  // immediately together with the state.
  assign busy      = (state_q == ADD);
  assign done      = (state_q == FIN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         error;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- clock
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- driver tasks
  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present operands with start high across one rising edge (edge 0).
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat = edges after capture, -1 on timeout.
  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 20; k++) begin
      if (!found) begin
        tick();
        if (done === 1'b1) begin
          found = 1'b1;
          lat   = k;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%0b exp=0", cout); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", error); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    #3 reset = 1'b0;
    tick();
  endtask

  // 1234 + 4321: digit-by-digit timing of busy, done and the partial sum.
  task automatic test_basic_timing();
    logic [W-1:0] exp_sum  [6];
    logic         exp_busy [6];
    logic         exp_done [6];
    exp_sum  = '{16'h0000, 16'h0005, 16'h0055, 16'h0555, 16'h5555, 16'h5555};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    start_op(16'h1234, 16'h4321, 1'b0);
    for (int e = 0; e < 6; e++) begin
      checks++; if (sum !== exp_sum[e]) begin failures++; $display("FAIL basic_sum_e%0d got=%h exp=%h", e, sum, exp_sum[e]); end
      checks++; if (busy !== exp_busy[e]) begin failures++; $display("FAIL basic_busy_e%0d got=%0b exp=%0b", e, busy, exp_busy[e]); end
      checks++; if (done !== exp_done[e]) begin failures++; $display("FAIL basic_done_e%0d got=%0b exp=%0b", e, done, exp_done[e]); end
      if (e == 4) begin
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%0b exp=0", cout); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL basic_error got=%0b exp=0", error); end
      end
      if (e < 5) tick();
    end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL basic_idle got=%0d exp=0", state_dbg); end
  endtask

  // 0858 + 0147 + 1: carries ripple through digits 0..2. Operands are
  // scrambled right after capture and must not affect the result.
  task automatic test_ripple();
    int lat;
    start_op(16'h0858, 16'h0147, 1'b1);
    a   = 16'h9999;
    b   = 16'h9999;
    cin = 1'b0;
    wait_done(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h1006) begin failures++; $display("FAIL ripple_sum got=%h exp=1006", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL ripple_cout got=%0b exp=0", cout); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ripple_done_width got=%0b exp=0", done); end
  endtask

  // 9999 + 0001: decimal overflow out of the top digit.
  task automatic test_overflow();
    int lat;
    logic [W-1:0] exp_s;
`ifdef BCD_SAT_EN
    exp_s = 16'h9999;
`else
    exp_s = 16'h0000;
`endif
    start_op(16'h9999, 16'h0001, 1'b0);
    wait_done(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
    checks++; if (sum !== exp_s) begin failures++; $display("FAIL ovf_sum got=%h exp=%h", sum, exp_s); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL ovf_cout got=%0b exp=1", cout); end
    tick();
    checks++; if (sum !== exp_s) begin failures++; $display("FAIL ovf_sum_hold got=%h exp=%h", sum, exp_s); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL ovf_cout_hold got=%0b exp=1", cout); end
  endtask

  // Invalid digits in A, then valid operands, then an invalid digit in B.
  task automatic test_error();
    int lat;
    start_op(16'h00A0, 16'h0000, 1'b0);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_a_early got=%0b exp=1", error); end
    wait_done(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL err_a_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h0100) begin failures++; $display("FAIL err_a_sum got=%h exp=0100", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL err_a_cout got=%0b exp=0", cout); end
    tick();
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_a_hold got=%0b exp=1", error); end

    start_op(16'h0001, 16'h0002, 1'b0);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", error); end
    wait_done(lat);
    checks++; if (sum !== 16'h0003) begin failures++; $display("FAIL err_clear_sum got=%h exp=0003", sum); end
    tick();

    // 0 + F = 15 -> digit 5, carry 1 -> 0015
    start_op(16'h0000, 16'h000F, 1'b0);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_b_early got=%0b exp=1", error); end
    wait_done(lat);
    checks++; if (sum !== 16'h0015) begin failures++; $display("FAIL err_b_sum got=%h exp=0015", sum); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_b_done got=%0b exp=1", error); end
    tick();
  endtask

  // Start at edge 0 with an invalid digit (error set; cout still 1 from the
  // overflow run), second start at edge 2 ignored, async reset mid-cycle
  // before edge 3, fresh start at edge 6.
  task automatic test_reset_mid();
    int lat;
    start_op(16'h111A, 16'h2222, 1'b0);          // edge 0
    tick();                                       // edge 1
    a     = 16'h5555;
    b     = 16'h4444;
    cin   = 1'b1;
    start = 1'b1;
    tick();                                       // edge 2
    start = 1'b0;
    // A+2=12 -> 2 carry 1; 1+2+1 = 4
    checks++; if (sum !== 16'h0042) begin failures++; $display("FAIL mid_sum_e2 got=%h exp=0042", sum); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_e2 got=%0b exp=1", busy); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL mid_error_e2 got=%0b exp=1", error); end
    #3 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%0b exp=0", done); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL mid_rst_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL mid_rst_cout got=%0b exp=0", cout); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL mid_rst_error got=%0b exp=0", error); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL mid_rst_state got=%0d exp=0", state_dbg); end
    tick();                                       // edge 3, reset held
    #3 reset = 1'b0;
    tick();                                       // edge 4
    tick();                                       // edge 5
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL mid_idle_e5 got=%0d exp=0", state_dbg); end
    start_op(16'h2500, 16'h2500, 1'b0);          // edge 6
    wait_done(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL mid_new_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h5000) begin failures++; $display("FAIL mid_new_sum got=%h exp=5000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL mid_new_cout got=%0b exp=0", cout); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL mid_new_error got=%0b exp=0", error); end
    tick();
  endtask

  // Start held high: done every DIGITS+2 = 6 cycles, never two in a row.
  task automatic test_back_to_back();
    int   lat;
    logic prev_done;
    logic exp_d;
    prev_done = 1'b0;
    a     = 16'h0005;
    b     = 16'h0005;
    cin   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();                                     // edge i
      exp_d = ((i % 6) == 4);
      checks++; if (done !== exp_d) begin failures++; $display("FAIL b2b_done_e%0d got=%0b exp=%0b", i, done, exp_d); end
      if (exp_d) begin
        checks++; if (sum !== 16'h0010) begin failures++; $display("FAIL b2b_sum_e%0d got=%h exp=0010", i, sum); end
      end
      checks++; if (prev_done === 1'b1 && done === 1'b1) begin failures++; $display("FAIL b2b_consecutive_e%0d got=11 exp=not both", i); end
      prev_done = done;
    end
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat < 0) begin failures++; $display("FAIL b2b_drain got=timeout exp=done"); end
    tick();
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_basic_timing();
    test_ripple();
    test_overflow();
    test_reset_mid();
    test_error();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit BCD adder that processes one digit pair per clock, least-significant digit first, using a one-digit BCD add/correct slice.
- Sits downstream of the switch/operand capture logic and upstream of the HEX display decoders.
- Operands are captured on Start; the result is held stable after Done until the next accepted Start.
- Invalid (>9) operand digits are flagged, matching the board's LEDR error convention.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1).

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- B  input  4*DIGITS  operand B, packed BCD.
- Cin  input  1  carry into digit 0.
- Busy  output  1  high while digits are being processed.
- Done  output  1  one-cycle pulse when Sum/Cout are valid.
- Sum  output  4*DIGITS  packed BCD result.
- Cout  output  1  decimal carry out of the top digit.
- Error  output  1  some captured operand digit was >9.

Behaviour:
- Interface: one clock (Clock); Reset is asynchronous and active-high.
- Reset (any time, including mid-operation): state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, Error=0, internal A/B/carry/index registers cleared.
- States: IDLE, ADD, FIN.
- IDLE to ADD on a Start=1 edge:
  - latch A, B and Cin into the carry register; digit index=0; Busy=1; Sum cleared to 0.
  - Error is set if any digit of A or B is greater than 9, otherwise cleared.
- ADD, each edge, for digit i = index:
  - t = a_i + b_i + carry, computed 5 bits wide (max 31).
  - If t>9: digit = (t+6)[3:0] and carry=1; else digit = t[3:0] and carry=0.
  - digit is written to Sum[4i+3:4i]; index increments.
- ADD to FIN on the edge that processes i = DIGITS-1: Cout = final carry; Busy=0; Done=1.
- FIN to IDLE on the next edge: Done=0. Sum, Cout and Error hold.
- Latency: Start sampled at edge 0; digit i is written at edge i+1; Done is high for exactly the cycle after edge DIGITS.
- Start while in ADD or FIN: ignored, with no effect on operands.
- Start held high: a new operation is accepted at the first IDLE edge, so the back-to-back period is DIGITS+2 cycles.
- A and B may change freely after the capture edge without affecting the result.
- Invalid digits: computation proceeds using the formula above; the result is defined but not decimal-valid. Error stays asserted until the next accepted Start.
- Sum digits not yet processed read 0 while Busy.

Optional Feature:
- Macro: BCD_SAT_EN.
- Defined: at the FIN transition, if the final carry is 1, Sum is forced to all 9s (every digit 4'h9) and Cout=1, i.e. saturating decimal add.
- Undefined: Sum is the wrapped result modulo 10^DIGITS and Cout reports the overflow.
- The Error logic is identical in both builds.

Test Plan:
- A=0x1234, B=0x4321, Cin=0, Start pulse at edge 0 -> Busy high for edges 1..4, Done high only in the cycle after edge 4, Sum=0x5555, Cout=0, Error=0.
- A=0x0858, B=0x0147, Cin=1 -> Sum=0x1006, Cout=0; carries ripple across digits 0..2.
- A=0x9999, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 without BCD_SAT_EN; Sum=0x9999, Cout=1 with BCD_SAT_EN.
- A=0x00A0, B=0x0000, Cin=0 -> Error=1 from the edge after capture; Sum=0x0100, Cout=0. The next Start with valid operands clears Error.
- Start at edge 0, second Start (different operands) at edge 2, Reset pulse at edge 3 (async, mid-cycle) -> second Start ignored; Busy, Done, Sum, Cout and Error drop to 0 immediately on Reset; state IDLE; a new Start at edge 6 completes normally.
- Start held high, A=0x0005, B=0x0005 -> Sum=0x0010, with Done pulses every DIGITS+2=6 cycles and never two consecutive cycles high.
